// File: rtl/data_sram_resp_if.sv
// Data-side SRAM request/response bundle between the
// execute/memory stages (master) and the data SRAM (slave).
interface data_sram_resp_if;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        stallreq;
  logic        addr_err;

  modport master (
    output data_sram_en,
    output data_sram_wen,
    output data_sram_addr,
    output data_sram_wdata,
    input  data_sram_rdata,
    input  stallreq,
    input  addr_err
  );

  modport slave (
    input  data_sram_en,
    input  data_sram_wen,
    input  data_sram_addr,
    input  data_sram_wdata,
    output data_sram_rdata,
    output stallreq,
    output addr_err
  );
endinterface

// File: rtl/data_sram_resp.sv
// Data SRAM responder: byte-masked writes, read-first registered data.
// Optional wait-state engine enabled by defining DSRAM_WAIT_EN.
module data_sram_resp #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  data_sram_resp_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic [1:0]        off;
  logic              is_wr;
  logic              mask_ok;
  logic              commit;
  logic              do_wr;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic              unused_hi;

  assign idx       = bus.data_sram_addr[ADDR_W+1:2];
  assign off       = bus.data_sram_addr[1:0];
  assign unused_hi = ^bus.data_sram_addr[31:ADDR_W+2];
  assign is_wr     = |bus.data_sram_wen;

  // Legal masks: naturally aligned byte, half or word.
  always_comb begin
    mask_ok = 1'b0;
    case (bus.data_sram_wen)
      4'b0001: mask_ok = (off == 2'd0);
      4'b0010: mask_ok = (off == 2'd1);
      4'b0100: mask_ok = (off == 2'd2);
      4'b1000: mask_ok = (off == 2'd3);
      4'b0011: mask_ok = (off == 2'd0);
      4'b1100: mask_ok = (off == 2'd2);
      4'b1111: mask_ok = (off == 2'd0);
      default: mask_ok = 1'b0;
    endcase
  end

`ifdef DSRAM_WAIT_EN
  generate
    if (WAIT_CYCLES == 0) begin : g_nowait
      assign commit       = bus.data_sram_en;
      assign bus.stallreq = 1'b0;
    end else begin : g_wait
      typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
      } state_t;

      localparam logic [3:0] CNT_INIT =
        (WAIT_CYCLES >= 2) ? 4'(WAIT_CYCLES - 2) : 4'd0;

      state_t     state;
      logic [3:0] cnt;

      // Wait-state sequencer; reset abandons any access in flight.
      always_ff @(posedge clk) begin
        if (rst) begin
          state <= IDLE;
          cnt   <= 4'd0;
        end else begin
          case (state)
            IDLE: begin
              if (bus.data_sram_en) begin
                if (WAIT_CYCLES == 1) begin
                  state <= DONE;
                end else begin
                  state <= WAIT;
                  cnt   <= CNT_INIT;
                end
              end
            end
            WAIT: begin
              if (cnt == 4'd0) state <= DONE;
              else             cnt   <= cnt - 4'd1;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
          endcase
        end
      end

      assign bus.stallreq = (state == WAIT) |
                            ((state == IDLE) & bus.data_sram_en);
      assign commit       = (state == DONE);
    end
  endgenerate
`else
  assign commit       = bus.data_sram_en;
  assign bus.stallreq = 1'b0;
`endif

  assign do_wr = commit & is_wr & mask_ok & ~rst;

  // Array update: only enabled byte lanes of a legal write change.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.data_sram_wen[i])
          mem[idx][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
      end
    end
  end

  // Read-first data register, held between commits.
  always_ff @(posedge clk) begin
    if (rst)         rdata_q <= 32'd0;
    else if (commit) rdata_q <= mem[idx];
  end

  // One-cycle pulse flagging a rejected write mask.
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= commit & is_wr & ~mask_ok;
  end

  assign bus.data_sram_rdata = rdata_q;
  assign bus.addr_err        = err_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// Scoreboard bench for data_sram_resp: directed plan items plus
// random traffic against a word-array reference model.
module tb_data_sram_resp;

`ifdef DSRAM_WAIT_EN
  localparam int W = 3;
`else
  localparam int W = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_sram_resp_if bus();

  data_sram_resp #(.ADDR_W(10), .WAIT_CYCLES(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          due;
    bit          chk_rd;
    logic [31:0] rd;
    logic        err;
    string       tag;
  } exp_t;

  exp_t        q[$];
  logic [31:0] ref_mem [1024];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares the response registered in this cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      if (e.due != cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: response missed at cycle %0d", e.tag, cyc);
      end else begin
        check({e.tag, "_err"}, {31'd0, bus.addr_err}, {31'd0, e.err});
        if (e.chk_rd) check({e.tag, "_rdata"}, bus.data_sram_rdata, e.rd);
      end
    end
  end

  function automatic bit legal(logic [3:0] wen, logic [1:0] a);
    int unsigned w;
    w = wen;
    if (w == (1 << a)) return 1'b1;
    if (w == 3  && a == 0) return 1'b1;
    if (w == 12 && a == 2) return 1'b1;
    if (w == 15 && a == 0) return 1'b1;
    return 1'b0;
  endfunction

  // Issue one access, hold it through the wait states, score it.
  task automatic access(string tag, logic [3:0] wen,
                        logic [31:0] addr, logic [31:0] wdata);
    exp_t        e;
    int          wi;
    logic [31:0] old;
    bus.data_sram_en    = 1'b1;
    bus.data_sram_wen   = wen;
    bus.data_sram_addr  = addr;
    bus.data_sram_wdata = wdata;
    for (int k = 0; k < W; k++) begin
      #1;
      check({tag, "_stall"}, {31'd0, bus.stallreq}, 32'd1);
      @(posedge clk);
      #1;
    end
    #1;
    check({tag, "_nostall"}, {31'd0, bus.stallreq}, 32'd0);
    wi  = (addr / 4) % 1024;
    old = ref_mem[wi];
    e.due    = cyc + 1;
    e.chk_rd = (wen == 4'd0);
    e.rd     = old;
    e.err    = (wen != 4'd0) && !legal(wen, addr[1:0]);
    e.tag    = tag;
    q.push_back(e);
    if (wen != 4'd0 && legal(wen, addr[1:0])) begin
      for (int b = 0; b < 4; b++)
        if (wen[b]) old[8*b +: 8] = wdata[8*b +: 8];
      ref_mem[wi] = old;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    bus.data_sram_en  = 1'b0;
    bus.data_sram_wen = 4'd0;
    repeat (n) begin
      #1;
      check("idle_stall", {31'd0, bus.stallreq}, 32'd0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_word(string tag, logic [31:0] addr, logic [31:0] v);
    checks++;
    if (ref_mem[(addr / 4) % 1024] !== v) begin
      errors++;
      $display("FAIL %s: model %h want %h", tag,
               ref_mem[(addr / 4) % 1024], v);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish in time");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    logic [3:0]  m;
    int          sz;

    bus.data_sram_en    = 1'b0;
    bus.data_sram_wen   = 4'd0;
    bus.data_sram_addr  = 32'd0;
    bus.data_sram_wdata = 32'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdata", bus.data_sram_rdata, 32'd0);
    check("rst_stall", {31'd0, bus.stallreq}, 32'd0);
    check("rst_err",   {31'd0, bus.addr_err}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 1024; i++)
      access("init", 4'hF, 32'(i * 4), $urandom);

    access("ww", 4'hF, 32'h10, 32'hDEADBEEF);
    access("wr", 4'h0, 32'h10, 32'h0);
    expect_word("ww_model", 32'h10, 32'hDEADBEEF);

    access("mw",  4'hF,    32'h20, 32'h11223344);
    access("mb",  4'b0010, 32'h21, 32'h0000AA00);
    access("mh",  4'b1100, 32'h22, 32'hBBBB0000);
    access("mr",  4'h0,    32'h20, 32'h0);
    expect_word("mask_model", 32'h20, 32'hBBBBAA44);

    access("ill",  4'b0011, 32'h21, 32'hFFFFFFFF);
    access("illr", 4'h0,    32'h20, 32'h0);
    expect_word("ill_model", 32'h20, 32'hBBBBAA44);
    idle(1);
    check("ill_pulse", {31'd0, bus.addr_err}, 32'd0);

    access("alw", 4'hF, 32'h00001004, 32'h5A5A5A5A);
    access("alr", 4'h0, 32'h00000004, 32'h0);
    expect_word("alias_model", 32'h4, 32'h5A5A5A5A);

`ifdef DSRAM_WAIT_EN
    idle(2);
    bus.data_sram_en    = 1'b1;
    bus.data_sram_wen   = 4'hF;
    bus.data_sram_addr  = 32'h40;
    bus.data_sram_wdata = ~ref_mem[16];
    for (int k = 0; k < 3; k++) begin
      #1;
      check("mid_stall", {31'd0, bus.stallreq}, 32'd1);
      if (k < 2) begin
        @(posedge clk);
        #1;
      end
    end
    rst = 1'b1;
    bus.data_sram_en  = 1'b0;
    bus.data_sram_wen = 4'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("mid_rdata", bus.data_sram_rdata, 32'd0);
    check("mid_stall0", {31'd0, bus.stallreq}, 32'd0);
    @(posedge clk);
    #1;
    access("midr", 4'h0, 32'h40, 32'h0);
`endif

    for (int n = 0; n < 400; n++) begin
      a = $urandom;
      case ($urandom_range(0, 9))
        0, 1, 2, 3: access("rrd", 4'h0, a, 32'h0);
        4: begin
          do m = 4'($urandom_range(1, 15));
          while (legal(m, a[1:0]));
          access("rill", m, a, $urandom);
        end
        default: begin
          sz = $urandom_range(0, 2);
          if (sz == 0) m = 4'(1 << a[1:0]);
          else if (sz == 1) begin
            a[0] = 1'b0;
            m = a[1] ? 4'b1100 : 4'b0011;
          end else begin
            a[1:0] = 2'd0;
            m = 4'hF;
          end
          access("rwr", m, a, $urandom);
        end
      endcase
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end

    idle(3);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d responses never checked", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
